oam_dma: RTL and testbench

- CPU-side DMA sequencer for the sprite unit's OAM port.
- On a $4014 write it halts the CPU and copies 256 bytes from CPU page XX00–XXFF into OAM through the same $2004 write path the CPU uses.
- It also arbitrates single-byte DMC sample fetches against the OAM copy on the shared CPU bus.
- Sits between the CPU core, the CPU memory map and the PPU register/sprite block.

---
 rtl/oam_dma.sv | 134 +++++++++++++
 tb/tb_oam_dma.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | oam_dma : halts the CPU, copies one 256-byte page into OAM and interleaves  |
// |           single-byte DMC sample fetches on the shared CPU bus.             |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module oam_dma #(
  parameter bit DMCPRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        cpurw,
  input  logic        wr4014,
  input  logic [7:0]  regwdata,
  input  logic        dmcreq,
  input  logic [15:0] dmcaddr,
  input  logic [7:0]  memrdata,
  output logic        cpuhalt,
  output logic        dmaact,
  output logic [15:0] dmaaddr,
  output logic        oamwr,
  output logic [7:0]  oamwdata,
  output logic        dmcack,
  output logic [7:0]  dmcdata
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HALT = 3'd1;
  localparam logic [2:0] c_SYNC = 3'd2;
  localparam logic [2:0] c_GET  = 3'd3;
  localparam logic [2:0] c_PUT  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        parity_q;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  latch_q, latch_d;
  logic        oampend_q, oampend_d;
  logic        dmcpend_q, dmcpend_d;
  logic [15:0] dmcaddr_q, dmcaddr_d;
  logic [7:0]  dmcdata_q, dmcdata_d;

  logic w_oam_new, w_dmc_new, w_get_dmc, w_get_oam, w_put;

  assign w_oam_new = wr4014 & ~oampend_q;
  assign w_dmc_new = dmcreq & ~dmcpend_q;
  assign w_get_dmc = (state_q == c_GET) & dmcpend_q & (DMCPRIO | ~oampend_q);
  assign w_get_oam = (state_q == c_GET) & ~w_get_dmc & oampend_q;
  assign w_put     = (state_q == c_PUT);

  always_comb begin
    page_d    = page_q;
    idx_d     = idx_q;
    latch_d   = latch_q;
    oampend_d = oampend_q;
    dmcpend_d = dmcpend_q;
    dmcaddr_d = dmcaddr_q;
    dmcdata_d = dmcdata_q;
    if (w_put) begin
      idx_d = idx_q + 8'd1;
      if (idx_q == 8'hFF) oampend_d = 1'b0;
    end
    if (w_oam_new) begin
      page_d    = regwdata;
      idx_d     = 8'd0;
      oampend_d = 1'b1;
    end
    if (w_get_oam) latch_d = memrdata;
    if (w_get_dmc) begin
      dmcdata_d = memrdata;
      dmcpend_d = 1'b0;
    end
    if (w_dmc_new) begin
      dmcpend_d = 1'b1;
      dmcaddr_d = dmcaddr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= c_IDLE;
      parity_q  <= 1'b0;
      page_q    <= 8'd0;
      idx_q     <= 8'd0;
      latch_q   <= 8'd0;
      oampend_q <= 1'b0;
      dmcpend_q <= 1'b0;
      dmcaddr_q <= 16'd0;
      dmcdata_q <= 8'd0;
    end else if (tick) begin
      state_q   <= state_d;
      parity_q  <= ~parity_q;
      page_q    <= page_d;
      idx_q     <= idx_d;
      latch_q   <= latch_d;
      oampend_q <= oampend_d;
      dmcpend_q <= dmcpend_d;
      dmcaddr_q <= dmcaddr_d;
      dmcdata_q <= dmcdata_d;
    end
  end

  // Requests arriving in the current tick count, so a same-tick request never idles.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (oampend_d | dmcpend_d) state_d = c_HALT;
      c_HALT: if (cpurw) state_d = parity_q ? c_GET : c_SYNC;
      c_SYNC: state_d = c_GET;
      c_GET: begin
        if (w_get_dmc)      state_d = oampend_d ? c_SYNC : c_IDLE;
        else if (w_get_oam) state_d = c_PUT;
        else                state_d = c_IDLE;
      end
      c_PUT:  state_d = (oampend_d | dmcpend_d) ? c_GET : c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    cpuhalt  = (state_q != c_IDLE);
    dmaact   = (state_q == c_GET);
    dmaaddr  = 16'd0;
    if (w_get_dmc)      dmaaddr = dmcaddr_q;
    else if (w_get_oam) dmaaddr = {page_q, idx_q};
    oamwr    = w_put;
    oamwdata = w_put ? latch_q : 8'd0;
    dmcack   = w_get_dmc;
    dmcdata  = dmcdata_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_oam_dma : directed self-checking bench for oam_dma.                      |
// | Rev 1.0 - initial release                                                   |
// +----------------------------------------------------------------------------+
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset, tick, cpurw, wr4014, dmcreq;
  logic [7:0]  regwdata;
  logic [15:0] dmcaddr;
  logic [7:0]  memrdata;
  logic        cpuhalt, dmaact, oamwr, dmcack;
  logic [15:0] dmaaddr;
  logic [7:0]  oamwdata, dmcdata;

  int checks = 0;
  int errors = 0;
  int ph, halt_cnt, wr_cnt, data_err, addr_err, overlap, dmc_cnt, first_get, stall_bus;
  logic [7:0]  exp_idx;
  logic [15:0] dmc_seen;

  always #5 clk = ~clk;

  oam_dma #(.DMCPRIO(1'b1)) dut (
    .clk(clk), .reset(reset), .tick(tick), .cpurw(cpurw), .wr4014(wr4014),
    .regwdata(regwdata), .dmcreq(dmcreq), .dmcaddr(dmcaddr), .memrdata(memrdata),
    .cpuhalt(cpuhalt), .dmaact(dmaact), .dmaaddr(dmaaddr), .oamwr(oamwr),
    .oamwdata(oamwdata), .dmcack(dmcack), .dmcdata(dmcdata)
  );

  // Memory image: page 0x02 holds i^0x5A, 0xC123 holds 0xA7, elsewhere lo^0x5A^hi.
  function automatic logic [7:0] mem_model(input logic [15:0] a);
    if (a == 16'hC123)      return 8'hA7;
    if (a[15:8] == 8'h02)   return a[7:0] ^ 8'h5A;
    return a[7:0] ^ 8'h5A ^ a[15:8];
  endfunction

  assign memrdata = mem_model(dmaaddr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    halt_cnt = 0; wr_cnt = 0; data_err = 0; addr_err = 0; overlap = 0;
    dmc_cnt = 0; first_get = -1; stall_bus = 0; exp_idx = 8'd0; dmc_seen = 16'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ph ^= 1;
    if (cpuhalt) halt_cnt++;
    if (dmaact && first_get < 0) first_get = halt_cnt;
    if (oamwr && dmaact) overlap++;
    if (dmaact && !dmcack && dmaaddr !== {8'h02, exp_idx}) addr_err++;
    if (dmcack) begin
      dmc_cnt++;
      dmc_seen = dmaaddr;
    end
    if (oamwr) begin
      if (oamwdata !== (exp_idx ^ 8'h5A)) data_err++;
      exp_idx++;
      wr_cnt++;
    end
  endtask

  task automatic align(input int p);
    int n = 0;
    while (ph != p && n < 4) begin
      step();
      n++;
    end
  endtask

  // One page-0x02 copy; optional HALT stall, DMC injection after dmc_at bytes, or reset at idx 0x80.
  task automatic run_copy(input int p, input int stall, input int dmc_at,
                          input logic [15:0] daddr, input bit do_rst);
    int  n = 0;
    bit  sent = 1'b0;
    align(p);
    clear_stats();
    regwdata = 8'h02; wr4014 = 1'b1; cpurw = 1'b0;
    step();
    wr4014 = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      if (dmaact || oamwr) stall_bus++;
    end
    cpurw = 1'b1;
    while (cpuhalt && n < 2000) begin
      dmcreq = 1'b0;
      if (do_rst && dmaact && wr_cnt == 128) begin
        reset = 1'b0;
        #1;
        check("reset_abort_outputs",
              {cpuhalt, dmaact, dmaaddr, oamwr, oamwdata, dmcack, dmcdata}, 64'd0);
        break;
      end
      if (!sent && dmc_at >= 0 && wr_cnt == dmc_at && oamwr) begin
        dmcreq = 1'b1; dmcaddr = daddr; sent = 1'b1;
      end
      step();
      n++;
    end
    dmcreq = 1'b0;
    check("copy_terminates", cpuhalt, 1'b0);
  endtask

  task automatic run_dmc(input int p, input logic [15:0] daddr);
    int n = 0;
    align(p);
    clear_stats();
    cpurw = 1'b1; dmcreq = 1'b1; dmcaddr = daddr;
    step();
    dmcreq = 1'b0;
    while (cpuhalt && n < 20) begin
      step();
      n++;
    end
    check("dmc_terminates", cpuhalt, 1'b0);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b1; cpurw = 1'b1; wr4014 = 1'b0; dmcreq = 1'b0;
    regwdata = 8'd0; dmcaddr = 16'd0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {cpuhalt, dmaact, dmaaddr, oamwr, oamwdata, dmcack, dmcdata}, 64'd0);
    reset = 1'b1;
    ph = 0;

    // Write on a get cycle: HALT + 256*(GET+PUT).
    run_copy(0, 0, -1, 16'h0, 1'b0);
    check("get_halt_cycles", halt_cnt, 513);
    check("get_first_get", first_get, 2);
    check("get_writes", wr_cnt, 256);
    check("get_data_err", data_err, 0);
    check("get_addr_err", addr_err, 0);
    check("get_overlap", overlap, 0);

    // Write on a put cycle: extra SYNC before the first GET.
    run_copy(1, 0, -1, 16'h0, 1'b0);
    check("put_halt_cycles", halt_cnt, 514);
    check("put_first_get", first_get, 3);
    check("put_data_err", data_err, 0);

    // Three stalled HALT cycles shift alignment onto a SYNC: 1+3+1+512.
    run_copy(0, 3, -1, 16'h0, 1'b0);
    check("stall_halt_cycles", halt_cnt, 517);
    check("stall_bus_quiet", stall_bus, 0);
    check("stall_writes", wr_cnt, 256);
    check("stall_data_err", data_err, 0);

    // Standalone DMC: HALT (+SYNC) + GET.
    run_dmc(0, 16'hC123);
    check("dmc_get_halt", halt_cnt, 2);
    check("dmc_get_acks", dmc_cnt, 1);
    check("dmc_get_addr", dmc_seen, 16'hC123);
    check("dmc_get_data", dmcdata, 8'hA7);
    run_dmc(1, 16'hC124);
    check("dmc_put_halt", halt_cnt, 3);
    check("dmc_put_data", dmcdata, 8'hBF);

    // DMC stolen mid-copy after idx 0x3F: +GET +SYNC.
    run_copy(0, 0, 64, 16'hC123, 1'b0);
    check("mid_halt_cycles", halt_cnt, 515);
    check("mid_acks", dmc_cnt, 1);
    check("mid_dmc_addr", dmc_seen, 16'hC123);
    check("mid_dmc_data", dmcdata, 8'hA7);
    check("mid_writes", wr_cnt, 256);
    check("mid_data_err", data_err, 0);
    check("mid_addr_err", addr_err, 0);
    check("mid_overlap", overlap, 0);

    // DMC in the tick of the last PUT: goes straight to GET, no idle gap.
    run_copy(0, 0, 256, 16'hC124, 1'b0);
    check("tail_halt_cycles", halt_cnt, 514);
    check("tail_acks", dmc_cnt, 1);
    check("tail_dmc_data", dmcdata, 8'hBF);
    check("tail_data_err", data_err, 0);

    // Reset at idx 0x80, then a fresh copy must restart at idx 0.
    run_copy(0, 0, -1, 16'h0, 1'b1);
    #3;
    reset = 1'b1;
    ph = 0;
    run_copy(0, 0, -1, 16'h0, 1'b0);
    check("restart_halt_cycles", halt_cnt, 513);
    check("restart_writes", wr_cnt, 256);
    check("restart_data_err", data_err, 0);
    check("restart_addr_err", addr_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
